// File: rtl/simple_uart_rx.sv
// rtl/simple_uart_rx.sv - 8N1 UART receiver with framing-error strobe.
// Optional macro SIMPLE_UART_RX_MAJORITY_EN: 2-of-3 majority vote on every sample.
module simple_uart_rx #(
    parameter int CLKS_PER_BIT = 417
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       busy
);

    localparam logic [15:0] C_HALF = 16'(CLKS_PER_BIT / 2);
    localparam logic [15:0] C_LAST = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t      r_state;
    logic        r_sync1;
    logic        r_sync2;
    logic [15:0] r_cnt;
    logic [2:0]  r_idx;
    logic [7:0]  r_shift;

    logic [15:0] w_m;
    logic        w_at_m;
    logic        w_sample;

    // Decision point: mid start bit while hunting, end of bit period afterwards.
    assign w_m    = (r_state == S_START) ? C_HALF : C_LAST;
    assign w_at_m = (r_cnt == w_m);

`ifdef SIMPLE_UART_RX_MAJORITY_EN
    logic r_tap0;
    logic r_tap1;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tap0 <= 1'b1;
            r_tap1 <= 1'b1;
        end else begin
            if (r_cnt == w_m - 16'd2) r_tap0 <= r_sync2;
            if (r_cnt == w_m - 16'd1) r_tap1 <= r_sync2;
        end
    end

    assign w_sample = (r_tap0 & r_tap1) | (r_tap0 & r_sync2) | (r_tap1 & r_sync2);
`else
    assign w_sample = r_sync2;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rx;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= 16'd0;
            r_idx     <= 3'd0;
            r_shift   <= 8'h00;
            rx_data   <= 8'h00;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (!r_sync2) begin
                        r_state <= S_START;
                        r_cnt   <= 16'd0;
                        busy    <= 1'b1;
                    end
                end
                S_START: begin
                    if (w_at_m) begin
                        r_cnt <= 16'd0;
                        if (!w_sample) begin
                            r_state <= S_DATA;
                            r_idx   <= 3'd0;
                        end else begin
                            r_state <= S_IDLE;
                            busy    <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                S_DATA: begin
                    if (w_at_m) begin
                        r_cnt   <= 16'd0;
                        r_shift <= {w_sample, r_shift[7:1]};
                        if (r_idx == 3'd7) begin
                            r_state <= S_STOP;
                        end else begin
                            r_idx <= r_idx + 3'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                S_STOP: begin
                    if (w_at_m) begin
                        r_cnt <= 16'd0;
                        if (w_sample) begin
                            rx_data  <= r_shift;
                            rx_valid <= 1'b1;
                            r_state  <= S_IDLE;
                            busy     <= 1'b0;
                        end else begin
                            frame_err <= 1'b1;
                            r_state   <= S_BREAK;
                        end
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                S_BREAK: begin
                    // Line held low past the stop bit: wait for idle before hunting again.
                    if (r_sync2) begin
                        r_state <= S_IDLE;
                        busy    <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= 16'd0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_simple_uart_rx.sv
// tb/tb_simple_uart_rx.sv - directed self-checking bench for simple_uart_rx.
module tb_simple_uart_rx;

    localparam int CPB = 417;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    int         v_edges[$];
    logic [7:0] v_data[$];
    int         f_edges[$];
    int         bad_overlap = 0;
    int         bad_long = 0;
    logic       prev_v = 1'b0;
    logic       prev_f = 1'b0;

    logic [7:0] exp_maj;
    int         fs;
    int         fs1;
    int         fs2;

    simple_uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Strobe recorder: edge number of each pulse, plus width/overlap violations.
    always @(negedge clk) begin
        if (rx_valid === 1'b1) begin
            v_edges.push_back(cyc);
            v_data.push_back(rx_data);
        end
        if (frame_err === 1'b1) f_edges.push_back(cyc);
        if (rx_valid === 1'b1 && frame_err === 1'b1) bad_overlap = bad_overlap + 1;
        if ((rx_valid === 1'b1 && prev_v) || (frame_err === 1'b1 && prev_f)) bad_long = bad_long + 1;
        prev_v = (rx_valid === 1'b1);
        prev_f = (frame_err === 1'b1);
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic go_to(input int n);
        while (cyc < n) step();
    endtask

    // Drives n_cycles of one frame; rx set here is sampled at edge f_start+i.
    task automatic send_frame(input logic [7:0] d, input logic stop_lvl, input int glitch_i,
                              input int n_cycles, output int f_start);
        int   b;
        logic lvl;
        f_start = cyc + 1;
        for (int i = 0; i < n_cycles; i++) begin
            b = i / CPB;
            if (b == 0) lvl = 1'b0;
            else if (b <= 8) lvl = d[b-1];
            else lvl = stop_lvl;
            if (glitch_i != 0 && i == glitch_i) lvl = 1'b0;
            rx = lvl;
            step();
        end
    endtask

    initial begin
        reset = 1'b1;
        rx    = 1'b1;
        repeat (3) step();
        check("rst_data", rx_data, 8'h00);
        check("rst_valid", rx_valid, 1'b0);
        check("rst_ferr", frame_err, 1'b0);
        check("rst_busy", busy, 1'b0);
        reset = 1'b0;
        repeat (5) step();
        check("idle_busy", busy, 1'b0);

        send_frame(8'h4B, 1'b1, 0, 10*CPB, fs);
        check("t1_count", v_edges.size(), 1);
        check("t1_edge", v_edges[0] - fs, 3964);
        check("t1_strobe_data", v_data[0], 8'h4B);
        check("t1_rx_data", rx_data, 8'h4B);
        check("t1_no_ferr", f_edges.size(), 0);
        check("t1_busy", busy, 1'b0);

        send_frame(8'h00, 1'b1, 0, 10*CPB, fs1);
        send_frame(8'hFF, 1'b1, 0, 10*CPB, fs2);
        check("t2_count", v_edges.size(), 3);
        check("t2_edge", v_edges[1] - fs1, 3964);
        check("t2_gap", v_edges[2] - v_edges[1], 4170);
        check("t2_data0", v_data[1], 8'h00);
        check("t2_data1", v_data[2], 8'hFF);

        repeat (20) step();
        fs = cyc + 1;
        rx = 1'b0;
        go_to(fs + 1);
        check("t3_busy_e1", busy, 1'b0);
        go_to(fs + 2);
        check("t3_busy_e2", busy, 1'b1);
        go_to(fs + 99);
        rx = 1'b1;
        go_to(fs + 210);
        check("t3_busy_e210", busy, 1'b1);
        go_to(fs + 211);
        check("t3_busy_e211", busy, 1'b0);
        repeat (20) step();
        check("t3_no_valid", v_edges.size(), 3);
        check("t3_no_ferr", f_edges.size(), 0);
        send_frame(8'h3C, 1'b1, 0, 10*CPB, fs);
        check("t3_count", v_edges.size(), 4);
        check("t3_data", v_data[3], 8'h3C);
        check("t3_rx_data", rx_data, 8'h3C);

        send_frame(8'h55, 1'b0, 0, 10*CPB, fs);
        check("t4_ferr_count", f_edges.size(), 1);
        check("t4_ferr_edge", f_edges[0] - fs, 3964);
        check("t4_no_valid", v_edges.size(), 4);
        check("t4_rx_data_kept", rx_data, 8'h3C);
        check("t4_busy_break", busy, 1'b1);
        repeat (5000) step();
        check("t4_busy_held", busy, 1'b1);
        check("t4_ferr_held", f_edges.size(), 1);
        rx = 1'b1;
        repeat (5) step();
        check("t4_busy_release", busy, 1'b0);
        check("t4_ferr_final", f_edges.size(), 1);
        check("t4_valid_final", v_edges.size(), 4);

        repeat (10) step();
        send_frame(8'h5A, 1'b1, 0, 5*CPB + 200, fs);
        check("t5_busy_mid", busy, 1'b1);
        reset = 1'b1;
        rx    = 1'b1;
        step();
        check("t5_rst_data", rx_data, 8'h00);
        check("t5_rst_valid", rx_valid, 1'b0);
        check("t5_rst_ferr", frame_err, 1'b0);
        check("t5_rst_busy", busy, 1'b0);
        reset = 1'b0;
        repeat (10) step();
        check("t5_no_valid", v_edges.size(), 4);
        send_frame(8'hA5, 1'b1, 0, 10*CPB, fs);
        check("t5_count", v_edges.size(), 5);
        check("t5_edge", v_edges[4] - fs, 3964);
        check("t5_rx_data", rx_data, 8'hA5);

`ifdef SIMPLE_UART_RX_MAJORITY_EN
        exp_maj = 8'hFF;
`else
        exp_maj = 8'hFE;
`endif
        repeat (10) step();
        send_frame(8'hFF, 1'b1, 626, 10*CPB, fs);
        check("t6_count", v_edges.size(), 6);
        check("t6_rx_data", rx_data, exp_maj);

        check("strobe_overlap", bad_overlap, 0);
        check("strobe_width", bad_long, 0);
        check("ferr_total", f_edges.size(), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
